// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared SoC bus: grants one requester, tracks begin/end, then releases.
// Optional watchdog (define BUS_ARB_TIMEOUT_EN) ends hung transactions with an arbiter-driven bus error.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int GRANT_WAIT     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_MASTERS-1:0] request_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [2:0]             grantIdx_o,
    output logic                   busActive_o,
    input  logic                   bus_beginTransaction_i,
    input  logic                   bus_endTransaction_i,
    input  logic                   bus_error_i,
    output logic                   bus_endTransaction_o,
    output logic                   bus_error_o
);

    localparam int WAIT_W = (GRANT_WAIT > 1) ? $clog2(GRANT_WAIT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("bus_arbiter_rr: NUM_MASTERS must be in 2..8");
    end
    if (GRANT_WAIT < 1) begin : g_bad_grant_wait
        $error("bus_arbiter_rr: GRANT_WAIT must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("bus_arbiter_rr: TIMEOUT_CYCLES must be in 1..65536");
    end

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0]            to_cnt_q, to_cnt_d;
    logic                   wd_fire_q, wd_fire_d;
`endif

    logic                   pick_found;
    logic [2:0]             pick_idx;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [2:0]             ptr_inc;
    logic                   bus_done;

    // First requester at or after the pointer, scanning with wrap-around.
    always_comb begin
        logic [3:0] cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cand        = '0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NUM_MASTERS)) cand = cand - 4'(NUM_MASTERS);
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!pick_found && request_i[j] && cand == 4'(j)) begin
                    pick_found     = 1'b1;
                    pick_idx       = 3'(j);
                    pick_onehot[j] = 1'b1;
                end
            end
        end
    end

    assign ptr_inc  = (idx_q == 3'(NUM_MASTERS - 1)) ? 3'd0 : idx_q + 3'd1;
    assign bus_done = bus_endTransaction_i | bus_error_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
`ifdef BUS_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        wd_fire_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (pick_found) begin
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                wait_d = wait_q + 1'b1;
                if (bus_beginTransaction_i) begin
`ifdef BUS_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    // A single-cycle transfer skips BUSY entirely.
                    if (bus_done) begin
                        grant_d = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else if ((request_i & grant_q) == '0 ||
                             wait_q == WAIT_W'(GRANT_WAIT - 1)) begin
                    grant_d = '0;
                    ptr_d   = ptr_inc;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus_done) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    wd_fire_d = 1'b1;
                    grant_d   = '0;
                    state_d   = ST_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            ST_RELEASE: begin
                ptr_d   = ptr_inc;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q  <= '0;
            wd_fire_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            wd_fire_q <= wd_fire_d;
        end
    end

    assign bus_endTransaction_o = wd_fire_q;
    assign bus_error_o          = wd_fire_q;
`else
    assign bus_endTransaction_o = 1'b0;
    assign bus_error_o          = 1'b0;
`endif

    assign grant_o     = grant_q;
    assign grantIdx_o  = idx_q;
    assign busActive_o = (state_q == ST_BUSY);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: table-driven cycle vectors plus hand-written corner sequences.
// Builds with or without BUS_ARB_TIMEOUT_EN; the watchdog section adapts to the macro.
module tb_bus_arbiter_rr;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] request_i = 4'h0;
    logic [3:0] grant_o;
    logic [2:0] grantIdx_o;
    logic       busActive_o;
    logic       bus_beginTransaction_i = 1'b0;
    logic       bus_endTransaction_i = 1'b0;
    logic       bus_error_i = 1'b0;
    logic       bus_endTransaction_o;
    logic       bus_error_o;

    int n_checks = 0;
    int n_errors = 0;
    int bad      = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       beg;
        logic       en;
        logic       er;
        logic [3:0] grant;
        logic [2:0] idx;
        logic       act;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    bus_arbiter_rr #(
        .NUM_MASTERS   (4),
        .GRANT_WAIT    (16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .request_i             (request_i),
        .grant_o               (grant_o),
        .grantIdx_o            (grantIdx_o),
        .busActive_o           (busActive_o),
        .bus_beginTransaction_i(bus_beginTransaction_i),
        .bus_endTransaction_i  (bus_endTransaction_i),
        .bus_error_i           (bus_error_i),
        .bus_endTransaction_o  (bus_endTransaction_o),
        .bus_error_o           (bus_error_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [2:0] idx,
                              input logic act);
        check({tag, " grant"}, 32'(grant_o), 32'(g));
        check({tag, " idx"}, 32'(grantIdx_o), 32'(idx));
        check({tag, " active"}, 32'(busActive_o), 32'(act));
        check({tag, " strobes"}, 32'({bus_endTransaction_o, bus_error_o}), 32'(0));
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic b, input logic e,
                                input logic er, input logic [3:0] g, input logic [2:0] idx,
                                input logic act);
        vec_t v;
        v.rst_n = r;  v.req = q;   v.beg = b;   v.en = e;
        v.er    = er; v.grant = g; v.idx = idx; v.act = act;
        return v;
    endfunction

    initial begin
        // Reset with all requests up, then four round-robin transactions (master 2 ends by error).
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'b0000, 3'd0, 0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'b0000, 3'd0, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0001, 3'd0, 0));
        vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0001, 3'd0, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0001, 3'd0, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0001, 3'd0, 1));
        vecs.push_back(mk(1, 4'hF, 0, 1, 0, 4'b0000, 3'd0, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 3'd0, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0010, 3'd1, 0));
        vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0010, 3'd1, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0010, 3'd1, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0010, 3'd1, 1));
        vecs.push_back(mk(1, 4'hF, 0, 1, 0, 4'b0000, 3'd1, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 3'd1, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0100, 3'd2, 0));
        vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b0100, 3'd2, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0100, 3'd2, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0100, 3'd2, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 1, 4'b0000, 3'd2, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 3'd2, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b1000, 3'd3, 0));
        vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'b1000, 3'd3, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b1000, 3'd3, 1));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b1000, 3'd3, 1));
        vecs.push_back(mk(1, 4'hF, 0, 1, 0, 4'b0000, 3'd3, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 3'd3, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0001, 3'd0, 0));
        // Single-cycle transfer, then request drop while granted.
        vecs.push_back(mk(1, 4'hF, 1, 1, 0, 4'b0000, 3'd0, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0000, 3'd0, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'b0010, 3'd1, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 4'b0000, 3'd1, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 4'b0000, 3'd1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_ni                 = vecs[i].rst_n;
            request_i              = vecs[i].req;
            bus_beginTransaction_i = vecs[i].beg;
            bus_endTransaction_i   = vecs[i].en;
            bus_error_i            = vecs[i].er;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].act);
        end
        bus_beginTransaction_i = 1'b0;
        bus_endTransaction_i   = 1'b0;
        bus_error_i            = 1'b0;

        // Grant withdrawal: held for GRANT_WAIT cycles with no begin, pointer moves to 3.
        request_i = 4'b0100;
        tick();
        check_outs("withdraw first", 4'b0100, 3'd2, 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("withdraw hold %0d", i), 32'(grant_o), 32'(4'b0100));
        end
        request_i = 4'b0101;
        tick();
        check_outs("withdrawn", 4'b0000, 3'd2, 0);
        tick();
        check_outs("wrap after withdraw", 4'b0001, 3'd0, 0);

        // Finish master 0, then grant master 1 and drop its request mid-transaction.
        bus_beginTransaction_i = 1'b1;
        tick();
        bus_beginTransaction_i = 1'b0;
        bus_endTransaction_i   = 1'b1;
        tick();
        bus_endTransaction_i = 1'b0;
        request_i            = 4'b0010;
        tick();
        tick();
        check_outs("drop grant", 4'b0010, 3'd1, 0);
        bus_beginTransaction_i = 1'b1;
        tick();
        check_outs("drop begin", 4'b0010, 3'd1, 1);
        bus_beginTransaction_i = 1'b0;
        request_i              = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs($sformatf("drop held %0d", i), 4'b0010, 3'd1, 1);
        end
        bus_endTransaction_i = 1'b1;
        tick();
        check_outs("drop released", 4'b0000, 3'd1, 0);
        bus_endTransaction_i = 1'b0;
        tick();
        check_outs("drop idle", 4'b0000, 3'd1, 0);

        // Hung transaction on master 2.
        request_i = 4'b0100;
        tick();
        check_outs("hang grant", 4'b0100, 3'd2, 0);
        bus_beginTransaction_i = 1'b1;
        tick();
        check_outs("hang begin", 4'b0100, 3'd2, 1);
        bus_beginTransaction_i = 1'b0;
        request_i              = 4'b0000;
`ifdef BUS_ARB_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (grant_o !== 4'b0100 || busActive_o !== 1'b1 ||
                bus_endTransaction_o !== 1'b0 || bus_error_o !== 1'b0) bad++;
        end
        check("watchdog quiet cycles", 32'(bad), 32'(0));
        tick();
        check("watchdog strobes", 32'({bus_endTransaction_o, bus_error_o}), 32'(2'b11));
        check("watchdog grant", 32'(grant_o), 32'(4'b0000));
        check("watchdog active", 32'(busActive_o), 32'(0));
        tick();
        check_outs("watchdog after", 4'b0000, 3'd2, 0);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (grant_o !== 4'b0100 || busActive_o !== 1'b1 ||
                bus_endTransaction_o !== 1'b0 || bus_error_o !== 1'b0) bad++;
        end
        check("hang held cycles", 32'(bad), 32'(0));
        check_outs("hang after 1000", 4'b0100, 3'd2, 1);
        bus_endTransaction_i = 1'b1;
        tick();
        bus_endTransaction_i = 1'b0;
        check_outs("hang ended", 4'b0000, 3'd2, 0);
        tick();
`endif

        // Reset in the middle of master 3's transaction returns the pointer to 0.
        request_i = 4'b1000;
        tick();
        check_outs("midreset grant", 4'b1000, 3'd3, 0);
        bus_beginTransaction_i = 1'b1;
        tick();
        check_outs("midreset busy", 4'b1000, 3'd3, 1);
        bus_beginTransaction_i = 1'b0;
        rst_ni                 = 1'b0;
        tick();
        check_outs("midreset cleared", 4'b0000, 3'd0, 0);
        rst_ni    = 1'b1;
        request_i = 4'hF;
        tick();
        check_outs("midreset pointer", 4'b0001, 3'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
